// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcodes, encoder token kinds and loader FSM states
package rv32i_pkg;
  typedef enum logic [3:0] {
    ENC_R, ENC_I_ALU, ENC_I_SHIFT, ENC_LOAD, ENC_STORE, ENC_BRANCH,
    ENC_JAL, ENC_JALR, ENC_LUI, ENC_AUIPC, ENC_SYSTEM
  } enc_kind_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} ldr_state_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_WORD  = 32'h00000013;
endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-token stream in, IMEM write port out
interface instr_encoder_loader_if #(parameter int AW = 10);
  import rv32i_pkg::*;
  logic            in_valid;
  logic            in_ready;
  enc_kind_t       in_kind;
  logic [2:0]      in_funct3;
  logic            in_alt;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [31:0]     in_imm;
  logic            in_last;
  logic            imem_we;
  logic            imem_ready;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_wdata;
  modport master (
    output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count; push+pop allowed when full
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_wr, w_rd;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_wr    = i_push && (!o_full || i_pop);
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rp];
  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= w_wr ? r_wp + AW'(1) : r_wp;
      r_rp    <= w_rd ? r_rp + AW'(1) : r_rp;
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  // Storage array needs no reset; only entries below the count are ever read
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I field tokens and writes them into IMEM; ENC_CHECKSUM_EN adds a checksum output
module instr_encoder_loader import rv32i_pkg::*; #(
  parameter int IMEM_AW    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  instr_encoder_loader_if.slave bus,
  output logic                 core_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 enc_err,
  output logic                 overflow,
  output logic [IMEM_AW:0]     word_count
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);
  localparam int CW = IMEM_AW + 1;
  ldr_state_t r_state;
  logic r_enc_vld;
  logic [31:0] r_enc_word;
  logic [CW-1:0] r_issued;
  logic [32:0] w_enc;
  logic [31:0] w_head;
  logic w_full, w_empty, w_pop, w_accept, w_drop, w_push_ok, w_start;

  function automatic logic [32:0] encode(input enc_kind_t k, input logic [2:0] f3, input logic alt,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] m);
    logic i_ok, b_ok, j_ok;
    logic [32:0] r;
    i_ok = (&m[31:11]) || !(|m[31:11]);
    b_ok = ((&m[31:12]) || !(|m[31:12])) && !m[0];
    j_ok = ((&m[31:20]) || !(|m[31:20])) && !m[0];
    case (k)
      ENC_R:       r = {1'b0, 1'b0, alt, 5'd0, rs2, rs1, f3, rd, OPC_OP};
      ENC_I_ALU:   r = {!i_ok, m[11:0], rs1, f3, rd, OPC_OP_IMM};
      ENC_I_SHIFT: r = {|m[31:5], 1'b0, alt, 5'd0, m[4:0], rs1, f3, rd, OPC_OP_IMM};
      ENC_LOAD:    r = {!i_ok, m[11:0], rs1, f3, rd, OPC_LOAD};
      ENC_STORE:   r = {!i_ok, m[11:5], rs2, rs1, f3, m[4:0], OPC_STORE};
      ENC_BRANCH:  r = {!b_ok, m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], OPC_BRANCH};
      ENC_JAL:     r = {!j_ok, m[20], m[10:1], m[11], m[19:12], rd, OPC_JAL};
      ENC_JALR:    r = {!i_ok, m[11:0], rs1, 3'b000, rd, OPC_JALR};
      ENC_LUI:     r = {|m[11:0], m[31:12], rd, OPC_LUI};
      ENC_AUIPC:   r = {|m[11:0], m[31:12], rd, OPC_AUIPC};
      ENC_SYSTEM:  r = {1'b0, 25'd0, OPC_SYSTEM};
      default:     r = {1'b1, NOP_WORD};
    endcase
    return r[32] ? {1'b1, NOP_WORD} : r;
  endfunction

  assign w_enc         = encode(bus.in_kind, bus.in_funct3, bus.in_alt, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
  assign bus.in_ready  = (r_state == S_LOAD) && !w_full;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_drop        = r_issued[IMEM_AW];
  assign w_push_ok     = !w_full || w_pop;
  assign w_pop         = bus.imem_we && bus.imem_ready;
  assign w_start       = start && (r_state == S_IDLE || r_state == S_DONE);
  assign bus.imem_we   = !w_empty;
  assign bus.imem_addr = word_count[IMEM_AW-1:0];
  assign bus.imem_wdata = w_head;

  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_enc_vld),
    .i_pop   (w_pop),
    .i_data  (r_enc_word),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Encoded-word stage: reloads whenever the FIFO can absorb what it currently holds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_enc_vld  <= 1'b0;
      r_enc_word <= '0;
    end else if (w_push_ok) begin
      r_enc_vld  <= w_accept && !w_drop;
      r_enc_word <= w_enc[31:0];
    end

  // Session FSM with registered status; tokens beyond IMEM capacity are dropped at acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      enc_err    <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      r_issued   <= '0;
    end else begin
      if (w_pop) word_count <= word_count + CW'(1);
      if (w_accept && !w_drop) r_issued <= r_issued + CW'(1);
      if (w_accept && !w_drop && w_enc[32]) enc_err <= 1'b1;
      if (w_accept && w_drop) overflow <= 1'b1;
      case (r_state)
        S_LOAD:  if (w_accept && bus.in_last) r_state <= S_FLUSH;
        S_FLUSH: if (w_empty && !r_enc_vld) begin
          r_state   <= S_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          core_hold <= 1'b0;
        end
        default: if (w_start) begin
          r_state    <= S_LOAD;
          busy       <= 1'b1;
          done       <= 1'b0;
          core_hold  <= 1'b1;
          enc_err    <= 1'b0;
          overflow   <= 1'b0;
          word_count <= '0;
          r_issued   <= '0;
        end
      endcase
    end

`ifdef ENC_CHECKSUM_EN
  // Running sum of every word IMEM accepted this session
  always_ff @(posedge clk or posedge rst)
    if (rst) checksum <= '0;
    else if (w_start) checksum <= '0;
    else if (w_pop) checksum <= checksum + w_head;
`endif
endmodule
